// File: rtl/button_pkg.sv
// Shared types and default parameters for the push-button input block.
// Contents:
//   btn_state_t       - per-button debounce FSM state
//   DEF_*             - default values for the button_input parameters
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESSING  = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } btn_state_t;

    localparam int DEF_N_BTN        = 3;
    localparam int DEF_PRESCALE_W   = 16;
    localparam int DEF_STABLE_TICKS = 16;
    localparam int DEF_HOLD_TICKS   = 1500;
    localparam int DEF_ACTIVE_LOW   = 0;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: two-flop synchroniser, debounce FSM with
// debounce and hold counters, and registered level/event outputs.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   tick       - one-cycle prescaler tick shared by all channels
//   pin_raw    - asynchronous raw pin
//   level      - debounced level, 1 = pressed
//   press      - one-cycle pulse when level rises
//   rel        - one-cycle pulse when level falls
//   hold       - one-cycle pulse after a long continuous press
module button_channel
    import button_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin_raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic hold
);

    localparam int DEB_W  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic              PIN_IDLE  = (ACTIVE_LOW != 0);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic              sync1_reg;
    logic              sync2_reg;
    logic              sync;
    btn_state_t        state_reg;
    logic [DEB_W-1:0]  deb_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              level_reg;
    logic              press_reg;
    logic              rel_reg;
    logic              hold_reg;

    // Synchroniser flops idle at the inactive pin value so that a pin held
    // through reset looks like a fresh edge once reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= PIN_IDLE;
            sync2_reg <= PIN_IDLE;
        end else begin
            sync1_reg <= pin_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign sync = sync2_reg ^ PIN_IDLE;

    // A sync change always wins over a coincident tick: the state reverts
    // and that tick does not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RELEASED;
            deb_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            level_reg    <= 1'b0;
            press_reg    <= 1'b0;
            rel_reg      <= 1'b0;
            hold_reg     <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            rel_reg   <= 1'b0;
            hold_reg  <= 1'b0;
            case (state_reg)
                RELEASED: begin
                    if (sync) begin
                        state_reg   <= PRESSING;
                        deb_cnt_reg <= '0;
                    end
                end
                PRESSING: begin
                    if (!sync) begin
                        state_reg <= RELEASED;
                    end else if (tick) begin
                        if (deb_cnt_reg == DEB_LAST) begin
                            state_reg    <= PRESSED;
                            level_reg    <= 1'b1;
                            press_reg    <= 1'b1;
                            hold_cnt_reg <= '0;
                        end else begin
                            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                        end
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        state_reg   <= RELEASING;
                        deb_cnt_reg <= '0;
                    end else if (tick && (hold_cnt_reg != HOLD_MAX)) begin
                        // Saturating count: once it reaches HOLD_MAX the
                        // hold pulse cannot fire again during this press.
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                        if (hold_cnt_reg == HOLD_LAST) begin
                            hold_reg <= 1'b1;
                        end
                    end
                end
                RELEASING: begin
                    // hold_cnt_reg is kept here so a release bounce cannot
                    // re-arm the hold event.
                    if (sync) begin
                        state_reg <= PRESSED;
                    end else if (tick) begin
                        if (deb_cnt_reg == DEB_LAST) begin
                            state_reg <= RELEASED;
                            level_reg <= 1'b0;
                            rel_reg   <= 1'b1;
                        end else begin
                            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= RELEASED;
                end
            endcase
        end
    end

    assign level = level_reg;
    assign press = press_reg;
    assign rel   = rel_reg;
    assign hold  = hold_reg;

endmodule

// File: rtl/button_input.sv
// Push-button input block: N_BTN raw pins are synchronised, debounced
// against a shared free-running prescaler tick, and turned into clean
// levels plus press/release/hold event pulses.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   btn_raw     - [1:N_BTN] asynchronous raw pins
//   btn_level   - [1:N_BTN] debounced level, 1 = pressed
//   btn_press   - [1:N_BTN] one-cycle pulse on level rise
//   btn_release - [1:N_BTN] one-cycle pulse on level fall
//   btn_hold    - [1:N_BTN] one-cycle pulse after HOLD_TICKS of press
module button_input
    import button_pkg::*;
#(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int PRESCALE_W   = DEF_PRESCALE_W,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:N_BTN]   btn_raw,
    output logic [1:N_BTN]   btn_level,
    output logic [1:N_BTN]   btn_press,
    output logic [1:N_BTN]   btn_release,
    output logic [1:N_BTN]   btn_hold
);

    logic [PRESCALE_W-1:0] prescale_reg;
    logic                  tick;

    // Free-running prescaler; the all-ones cycle is the tick and the
    // counter wraps to zero on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_reg <= '0;
        end else begin
            prescale_reg <= prescale_reg + PRESCALE_W'(1);
        end
    end

    assign tick = &prescale_reg;

    genvar gi;
    generate
        for (gi = 1; gi <= N_BTN; gi++) begin : g_chan
            button_channel #(
                .STABLE_TICKS (STABLE_TICKS),
                .HOLD_TICKS   (HOLD_TICKS),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .tick    (tick),
                .pin_raw (btn_raw[gi]),
                .level   (btn_level[gi]),
                .press   (btn_press[gi]),
                .rel     (btn_release[gi]),
                .hold    (btn_hold[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input with a fast prescaler
// (tick every 4 cycles, 3 stable ticks, hold after 5 ticks).
module tb_button_input;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:N]   btn_raw;
    logic [1:N]   btn_level;
    logic [1:N]   btn_press;
    logic [1:N]   btn_release;
    logic [1:N]   btn_hold;

    button_input #(
        .N_BTN        (N),
        .PRESCALE_W   (2),
        .STABLE_TICKS (3),
        .HOLD_TICKS   (5),
        .ACTIVE_LOW   (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // kind: 0 = press, 1 = release, 2 = hold; window in cycle numbers
    typedef struct {
        int kind;
        int b;
        int lo;
        int hi;
    } ev_t;
    ev_t sb[$];

    int press_cyc [1:N];
    bit simul = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic string kname(input int kind);
        case (kind)
            0:       return "press";
            1:       return "release";
            default: return "hold";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int b, input int lo, input int hi);
        ev_t e;
        e.kind = kind; e.b = b; e.lo = lo; e.hi = hi;
        sb.push_back(e);
        $display("push %s b%0d window [%0d,%0d]", kname(kind), b, lo, hi);
    endtask

    task automatic match_ev(input int kind, input int b, input int bitv);
        int idx;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].kind == kind && sb[i].b == b) idx = i;
        if (idx < 0) begin
            check($sformatf("stray_%s_b%0d", kname(kind), b), bitv, 0);
        end else begin
            $display("pop %s b%0d at cycle %0d window [%0d,%0d]",
                     kname(kind), b, cyc, sb[idx].lo, sb[idx].hi);
            check($sformatf("%s_b%0d_in_window", kname(kind), b),
                  int'(cyc >= sb[idx].lo && cyc <= sb[idx].hi), 1);
            sb.delete(idx);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("outs_in_reset", int'({btn_level, btn_press, btn_release, btn_hold}), 0);
        end else begin
            for (int b = 1; b <= N; b++) begin
                if (btn_press[b]) begin
                    match_ev(0, b, int'(btn_press[b]));
                    check($sformatf("level_with_press_b%0d", b), int'(btn_level[b]), 1);
                    press_cyc[b] = cyc;
                end
                if (btn_release[b]) begin
                    match_ev(1, b, int'(btn_release[b]));
                    check($sformatf("level_with_release_b%0d", b), int'(btn_level[b]), 0);
                end
                if (btn_hold[b]) begin
                    match_ev(2, b, int'(btn_hold[b]));
                    check($sformatf("hold_after_press_b%0d", b),
                          int'((cyc - press_cyc[b]) >= 16 && (cyc - press_cyc[b]) <= 24), 1);
                end
            end
            if (simul && btn_press != '0) check("simul_press", int'(btn_press), 7);
            if (simul && btn_release != '0) check("simul_release", int'(btn_release), 7);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        int q;
        for (int b = 1; b <= N; b++) press_cyc[b] = -1000;
        rst_n   = 1'b0;
        btn_raw = '0;
        step(3);
        rst_n = 1'b1;
        step(1);
        check("idle_level", int'(btn_level), 0);
        check("idle_pulses", int'({btn_press, btn_release, btn_hold}), 0);
        step(4);

        // Clean press and release of button 1.
        btn_raw[1] = 1'b1;
        expect_ev(0, 1, cyc + 12, cyc + 15);
        step(18);
        btn_raw[1] = 1'b0;
        expect_ev(1, 1, cyc + 12, cyc + 15);
        step(20);
        check("sb_empty_clean", sb.size(), 0);

        // Bouncy press of button 2: toggles every 3 cycles, then held.
        for (int i = 0; i < 10; i++) begin
            btn_raw[2] = ~btn_raw[2];
            step(3);
        end
        btn_raw[2] = 1'b1;
        expect_ev(0, 2, cyc + 12, cyc + 15);
        step(18);
        btn_raw[2] = 1'b0;
        expect_ev(1, 2, cyc + 12, cyc + 15);
        step(20);
        check("sb_empty_bouncy", sb.size(), 0);

        // Long hold of button 3 with a release bounce in the middle.
        btn_raw[3] = 1'b1;
        expect_ev(0, 3, cyc + 12, cyc + 15);
        expect_ev(2, 3, cyc + 28, cyc + 39);
        step(46);
        btn_raw[3] = 1'b0;
        step(3);
        check("level_during_bounce", int'(btn_level[3]), 1);
        step(2);
        btn_raw[3] = 1'b1;
        step(4);
        check("level_after_bounce", int'(btn_level[3]), 1);
        step(5);
        btn_raw[3] = 1'b0;
        expect_ev(1, 3, cyc + 12, cyc + 15);
        step(20);
        check("level_after_release", int'(btn_level[3]), 0);
        check("sb_empty_hold", sb.size(), 0);

        // All three buttons on the same edge.
        simul = 1'b1;
        btn_raw = '1;
        for (int b = 1; b <= N; b++) expect_ev(0, b, cyc + 12, cyc + 15);
        step(18);
        check("simul_level", int'(btn_level), 7);
        btn_raw = '0;
        for (int b = 1; b <= N; b++) expect_ev(1, b, cyc + 12, cyc + 15);
        step(20);
        simul = 1'b0;
        check("sb_empty_simul", sb.size(), 0);

        // Reset in the middle of a hold with button 1 still pressed.
        start = cyc;
        btn_raw[1] = 1'b1;
        expect_ev(0, 1, cyc + 12, cyc + 15);
        for (int i = 0; i < 40 && press_cyc[1] < start; i++) step(1);
        check("rst_scn_press_seen", int'(press_cyc[1] >= start), 1);
        for (int i = 0; i < 40 && cyc < press_cyc[1] + 13; i++) step(1);
        rst_n = 1'b0;
        step(3);
        check("outs_mid_reset", int'({btn_level, btn_press, btn_release, btn_hold}), 0);
        rst_n = 1'b1;
        q = cyc;
        expect_ev(0, 1, q + 12, q + 15);
        expect_ev(2, 1, q + 28, q + 39);
        step(45);
        btn_raw[1] = 1'b0;
        expect_ev(1, 1, cyc + 12, cyc + 15);
        step(20);
        check("sb_final", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
